ram_arb: RTL
============

RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 SHALL have parameter ACC_CYC, default 4, meaning cycles each background access holds memory strobes (legal range 2..15).
REQ-002 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; synchronous, active-low.
REQ-004 SHALL have port rt_ce  in  1  real-time CPU cart access request (highest priority).
REQ-005 SHALL have ports rt_addr  in  23, rt_dati  in  8, rt_oe  in  1, rt_we  in  1  real-time access address, write data, strobes.
REQ-006 SHALL have port req  in  3  background requests; bit0 dma, bit1 mem_io, bit2 sst.
REQ-007 SHALL have port req_we  in  3  per-channel write flag (1 = write, 0 = read).
REQ-008 SHALL have ports req_addr  in  69 and req_dati  in  24  per-channel address/data, channel n at [23n+22:23n] and [8n+7:8n].
REQ-009 SHALL have port ack  out  3  one-cycle completion pulse per channel.
REQ-010 SHALL have port rd_data  out  8  read data, valid while ack is high.
REQ-011 SHALL have ports mem_addr  out  23, mem_dati  out  8, mem_ce  out  1, mem_oe  out  1, mem_we  out  1  memory port.
REQ-012 SHALL have port mem_dato  in  8  memory read data.
REQ-013 SHALL have port busy  out  1  high whenever FSM is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ACC, HOLD, ACK; registered state, counter cnt (4 bit), selected channel sel (2 bit), round-robin pointer ptr (2 bit).
REQ-015 rt_ce=1 SHALL drive mem_addr/mem_dati/mem_oe/mem_we combinationally from rt_* with mem_ce=1, same cycle, in every FSM state.
REQ-016 IDLE with rt_ce=0 and req!=0 SHALL select first set bit scanning ptr+1, ptr+2, ptr+3 (mod 3), latch addr/data/we of that channel, set cnt=0, go ACC.
REQ-017 IDLE with rt_ce=1 SHALL NOT start an access; req stays pending.
REQ-018 ACC with rt_ce=0 SHALL drive latched addr/data, mem_ce=1, mem_oe=!we, mem_we=we; cnt increments each cycle.
REQ-019 ACC at cnt==ACC_CYC-1 SHALL register mem_dato into rd_data (reads only; writes leave rd_data unchanged) and go ACK.
REQ-020 ACC with rt_ce=1 SHALL go HOLD, keep sel and latched data, clear cnt.
REQ-021 HOLD SHALL stay while rt_ce=1 and return to ACC with cnt=0 (full access restarted) on first cycle rt_ce=0.
REQ-022 ACK SHALL assert ack[sel]=1 for exactly one cycle, set ptr=sel, go IDLE.
REQ-023 Requester SHALL drop req by the cycle after ack; req still high in the IDLE cycle after ACK counts as a new request.
REQ-024 req deasserted during ACC/HOLD SHALL be ignored; access completes and ack still issues.
REQ-025 req deasserted in IDLE before selection SHALL withdraw the request with no side effect.
REQ-026 With rt_ce=0 and no background access, mem_ce/mem_oe/mem_we SHALL be 0, mem_addr and mem_dati 0.
REQ-027 With rt_ce held 0, any continuously requesting channel SHALL be acked within 3 background accesses (3*(ACC_CYC+2) cycles).
REQ-028 At most one ack bit SHALL be high in any cycle.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force state=IDLE, cnt=0, sel=0, ptr=2 (dma scanned first), ack=0, rd_data=0, busy=0, aborting any access without ack.
REQ-030 During and after reset, mem_* SHALL obey REQ-015/REQ-026 (real-time path unaffected by reset).

Verification
REQ-031 Single read: ACC_CYC=4, req=001, req_we=0, addr 0x000123, mem_dato=0x5A -> mem_ce high 4 cycles, ack=001 with rd_data=0x5A on 6th cycle after req sampled.
REQ-032 Round-robin: req=111 held, rt_ce=0, after reset -> ack order 001, 010, 100, 001.
REQ-033 Preemption: write ch1 data 0xC3, rt_ce pulsed 3 cycles at cnt=2 -> mem follows rt_* those cycles, HOLD, then 4 fresh ACC cycles with mem_we=1, single ack=010.
REQ-034 rt_ce held high 20 cycles with req=100 -> no ack, busy=0, mem_addr=rt_addr throughout; ack=100 arrives ACC_CYC+1 cycles after rt_ce drops.
REQ-035 Reset mid-access: rst_n=0 at cnt=1 -> next cycle state IDLE, ack=0, rd_data=0, mem_ce=0; dma served first after release.
REQ-036 Withdrawal: req=010 asserted in a cycle with rt_ce=1, dropped before rt_ce falls -> no access, no ack, busy stays 0.

Source files
------------

// File: rtl/ram_arb.sv
// ---------------------------------------------------------------------------
// ram_arb
// Shares one external cart RAM between a real-time CPU port and three
// background requesters (dma, mem_io, sst).
//
// The real-time port always wins. Whenever rt_ce is high it drives the memory
// pins directly in the same cycle, regardless of what the background side is
// doing. Background accesses hold the strobes for ACC_CYC cycles. Legal values
// of ACC_CYC are 2..15. An access that the real-time port interrupts is
// parked. It then restarts from scratch once the real-time port lets go.
// Background channels are served round-robin, starting after the channel that
// was served last.
//
// Ports
//   clk, rst_n        : clock (rising edge), synchronous active-low reset
//   rt_ce             : real-time access request, highest priority
//   rt_addr/rt_dati   : real-time address (23b) and write data (8b)
//   rt_oe/rt_we       : real-time strobes
//   req[2:0]          : background requests (0 dma, 1 mem_io, 2 sst)
//   req_we[2:0]       : per-channel write flag (1 write, 0 read)
//   req_addr[68:0]    : per-channel address, channel n at [23n+22:23n]
//   req_dati[23:0]    : per-channel write data, channel n at [8n+7:8n]
//   ack[2:0]          : one-cycle completion pulse per channel
//   rd_data[7:0]      : read data, valid while ack is high
//   mem_addr/mem_dati : memory address / write data
//   mem_ce/oe/we      : memory strobes
//   mem_dato[7:0]     : memory read data
//   busy              : background engine not idle
// ---------------------------------------------------------------------------
module ram_arb #(
  parameter int unsigned ACC_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rt_ce,
  input  logic [22:0] rt_addr,
  input  logic [7:0]  rt_dati,
  input  logic        rt_oe,
  input  logic        rt_we,
  input  logic [2:0]  req,
  input  logic [2:0]  req_we,
  input  logic [68:0] req_addr,
  input  logic [23:0] req_dati,
  output logic [2:0]  ack,
  output logic [7:0]  rd_data,
  output logic [22:0] mem_addr,
  output logic [7:0]  mem_dati,
  output logic        mem_ce,
  output logic        mem_oe,
  output logic        mem_we,
  input  logic [7:0]  mem_dato,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2,
    ACK  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACC_CYC - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [1:0]  r_sel;
  logic [1:0]  r_ptr;
  logic [22:0] r_addr;
  logic [7:0]  r_dati;
  logic        r_we;
  logic [2:0]  r_ack;
  logic [7:0]  r_rd;

  logic [1:0]  w_c1;
  logic [1:0]  w_c2;
  logic [1:0]  w_pick;
  logic [22:0] w_addr;
  logic [7:0]  w_dati;

  // Scan order is ptr+1, ptr+2, then ptr itself, all modulo 3. If neither of
  // the first two is requesting, the fall-through pick is ptr. That pick is
  // only used when req is nonzero, so ptr must then be the requester.
  always_comb begin
    w_c1   = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
    w_c2   = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
    w_pick = r_ptr;
    if (req[w_c1]) begin
      w_pick = w_c1;
    end else if (req[w_c2]) begin
      w_pick = w_c2;
    end
  end

  // Extract the address and data fields of the channel that won the scan.
  always_comb begin
    w_addr = req_addr[22:0];
    w_dati = req_dati[7:0];
    case (w_pick)
      2'd1: begin
        w_addr = req_addr[45:23];
        w_dati = req_dati[15:8];
      end
      2'd2: begin
        w_addr = req_addr[68:46];
        w_dati = req_dati[23:16];
      end
      default: begin
        w_addr = req_addr[22:0];
        w_dati = req_dati[7:0];
      end
    endcase
  end

  // Background access engine. ack is registered on the way into ACK, so it
  // is high for exactly the one cycle spent in ACK. The real-time port can
  // interrupt an access at any point. The interrupted access then waits in
  // HOLD and restarts with a full ACC_CYC strobe window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd2;
      r_addr  <= 23'd0;
      r_dati  <= 8'd0;
      r_we    <= 1'b0;
      r_ack   <= 3'b000;
      r_rd    <= 8'd0;
    end else begin
      r_ack <= 3'b000;
      case (r_state)
        IDLE: begin
          if (!rt_ce && (req != 3'b000)) begin
            r_sel   <= w_pick;
            r_addr  <= w_addr;
            r_dati  <= w_dati;
            r_we    <= req_we[w_pick];
            r_cnt   <= 4'd0;
            r_state <= ACC;
          end
        end
        ACC: begin
          if (rt_ce) begin
            r_cnt   <= 4'd0;
            r_state <= HOLD;
          end else if (r_cnt == LAST_CNT) begin
            if (!r_we) begin
              r_rd <= mem_dato;
            end
            r_ack   <= 3'b001 << r_sel;
            r_state <= ACK;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        HOLD: begin
          if (!rt_ce) begin
            r_cnt   <= 4'd0;
            r_state <= ACC;
          end
        end
        ACK: begin
          r_ptr   <= r_sel;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Memory pin mux. The real-time port bypasses all state, including reset.
  // Otherwise the pins carry the latched background access only in ACC,
  // and are parked at zero in every other state.
  always_comb begin
    mem_addr = 23'd0;
    mem_dati = 8'd0;
    mem_ce   = 1'b0;
    mem_oe   = 1'b0;
    mem_we   = 1'b0;
    if (rt_ce) begin
      mem_addr = rt_addr;
      mem_dati = rt_dati;
      mem_ce   = 1'b1;
      mem_oe   = rt_oe;
      mem_we   = rt_we;
    end else if (r_state == ACC) begin
      mem_addr = r_addr;
      mem_dati = r_dati;
      mem_ce   = 1'b1;
      mem_oe   = !r_we;
      mem_we   = r_we;
    end
  end

  assign ack     = r_ack;
  assign rd_data = r_rd;
  assign busy    = (r_state != IDLE);

endmodule
